// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the uart_sink receive slice.
// Holds the FSM state enum, oversampling constants and the divisor helper.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int SAMPLE_TICK = 8;
  localparam int DATA_BITS   = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  // Clocks per oversample tick, floored, never below 1.
  function automatic int calc_div(
    input int clk_hz,
    input int baud
  );
    int d;
    d = clk_hz / (OVERSAMPLE * baud);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_sink_fifo.sv
// uart_sink_fifo: synchronous byte FIFO with registered head-of-queue data.
// Ports: push/wdata in, pop in, rdata/full/empty/count out; rst sync low.
module uart_sink_fifo #(
  parameter int depth = 16,
  parameter int width = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [width-1:0]       wdata,
  input  logic                   pop,
  output logic [width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [CW-1:0]    left;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_nxt  = rd_ptr + AW'(do_pop);
  assign left    = count - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // rdata tracks the head after this cycle's pop/push; a push into
  // an otherwise empty queue is forwarded straight into the register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      count  <= left + CW'(do_push);
      if (left != '0) rdata <= mem[rd_nxt];
      else if (do_push) rdata <= wdata;
    end
  end

endmodule

// File: rtl/uart_sink.sv
// uart_sink: 16x oversampling 8N1 UART receiver feeding a byte FIFO.
// Ports: clk, rst (sync low), uart_rxd in; rx_data/rx_valid/rx_ready
// byte port; fifo_count; sticky frame_err/overrun cleared by err_clr.
// UART_SINK_PARITY_EN adds an even-parity bit and sticky parity_err.
module uart_sink
  import uart_pkg::*;
#(
  parameter int clk_freq   = 50000000,
  parameter int baud_rate  = 1152000,
  parameter int fifo_depth = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        uart_rxd,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(fifo_depth):0] fifo_count,
  output logic                        frame_err,
  output logic                        overrun,
`ifdef UART_SINK_PARITY_EN
  output logic                        parity_err,
`endif
  input  logic                        err_clr
);

  localparam int DIV = calc_div(clk_freq, baud_rate);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  state_t          state, state_n;
  logic [1:0]      sync;
  logic            rxd_s;
  logic            rxd_prev;
  logic [DW-1:0]   div_cnt;
  logic [TW-1:0]   tick_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [7:0]      shreg;
  logic [7:0]      byte_q;
  logic            tick;
  logic            mid;
  logic            push_n;
  logic            push_q;
  logic            ferr_set;
  logic            par_ok;
  logic            full;
  logic            empty;
  logic            drop;

  assign rxd_s = sync[1];
  assign tick  = (state != IDLE) && (div_cnt == DW'(DIV - 1));
  assign mid   = tick && (tick_cnt == TW'(SAMPLE_TICK - 1));

`ifdef UART_SINK_PARITY_EN
  logic perr_set;
  logic par_bad;
  assign par_ok = !par_bad;
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_n  = state;
    push_n   = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_SINK_PARITY_EN
    perr_set = 1'b0;
`endif
    unique case (state)
      IDLE:
        if (rxd_prev && !rxd_s) state_n = START;
      START:
        if (mid) state_n = rxd_s ? IDLE : DATA;
      DATA:
        if (mid && bit_cnt == BW'(DATA_BITS - 1))
`ifdef UART_SINK_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
`ifdef UART_SINK_PARITY_EN
      PARITY:
        if (mid) begin
          state_n  = STOP;
          perr_set = (^shreg) != rxd_s;
        end
`endif
      STOP:
        if (mid) begin
          if (rxd_s) begin
            push_n  = par_ok;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = WAIT_HIGH;
          end
        end
      WAIT_HIGH:
        if (rxd_s) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // Tick and bit counters hold at zero while idle so each frame
  // starts its oversample phase from the detected falling edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync     <= 2'b11;
      rxd_prev <= 1'b1;
      state    <= IDLE;
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      byte_q   <= '0;
      push_q   <= 1'b0;
    end else begin
      sync     <= {sync[0], uart_rxd};
      rxd_prev <= rxd_s;
      state    <= state_n;
      push_q   <= push_n;
      if (push_n) byte_q <= shreg;
      if (state == IDLE) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        if (tick) tick_cnt <= tick_cnt + TW'(1);
        if (mid && state == DATA) begin
          shreg   <= {rxd_s, shreg[7:1]};
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

`ifdef UART_SINK_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == IDLE) par_bad <= 1'b0;
      else if (perr_set) par_bad <= 1'b1;
      parity_err <= perr_set | (parity_err & ~err_clr);
    end
  end
`endif

  assign drop = push_q && full && !(rx_ready && !empty);

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set | (frame_err & ~err_clr);
      overrun   <= drop | (overrun & ~err_clr);
    end
  end

  assign rx_valid = !empty;

  uart_sink_fifo #(
    .depth (fifo_depth),
    .width (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdata (byte_q),
    .pop   (rx_ready),
    .rdata (rx_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_uart_sink.sv
// tb_uart_sink: directed frames against uart_sink at default parameters.
// One bit = 32 clocks; outputs sampled on the falling clock edge.
module tb_uart_sink;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] fifo_count;
  logic       frame_err;
  logic       overrun;
`ifdef UART_SINK_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  uart_sink dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rxd   (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_SINK_PARITY_EN
    .parity_err (parity_err),
`endif
    .err_clr    (err_clr)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives start, data (and parity), then the stop bit; returns
  // right after the stop bit is put on the line.
  task automatic send(input logic [7:0] b, input logic sb);
    @(negedge clk);
    rxd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_n(32);
      rxd = b[i];
    end
`ifdef UART_SINK_PARITY_EN
    wait_n(32);
    rxd = (^b) ^ par_flip;
`endif
    wait_n(32);
    rxd = sb;
  endtask

  task automatic frame(input logic [7:0] b);
    send(b, 1'b1);
    wait_n(32);
  endtask

  task automatic pop1;
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clr1;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    wait_n(3);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    rst = 1'b1;
    wait_n(4);

    // 0x55: visible exactly two cycles after the stop sample
    send(8'h55, 1'b1);
    wait_n(19);
    chk("t1_valid_n1", 32'(rx_valid), 0);
    chk("t1_count_n1", 32'(fifo_count), 0);
    wait_n(1);
    chk("t1_valid_n2", 32'(rx_valid), 1);
    chk("t1_count_n2", 32'(fifo_count), 1);
    chk("t1_data", 32'(rx_data), 'h55);
    wait_n(12);
    pop1();
    chk("t1_pop_valid", 32'(rx_valid), 0);
    chk("t1_pop_count", 32'(fifo_count), 0);

    // 0xA3 with low stop bit, line held low, then 0x3C
    send(8'hA3, 1'b0);
    wait_n(18);
    chk("t2_ferr_n", 32'(frame_err), 0);
    wait_n(1);
    chk("t2_ferr_n1", 32'(frame_err), 1);
    wait_n(81);
    rxd = 1'b1;
    wait_n(20);
    chk("t2_no_push", 32'(fifo_count), 0);
    frame(8'h3C);
    chk("t2_count", 32'(fifo_count), 1);
    chk("t2_data", 32'(rx_data), 'h3C);
    chk("t2_ferr_sticky", 32'(frame_err), 1);
    clr1();
    chk("t2_ferr_clr", 32'(frame_err), 0);
    pop1();

    // 6-clock glitch, then 0x81
    @(negedge clk);
    rxd = 1'b0;
    wait_n(6);
    rxd = 1'b1;
    wait_n(40);
    chk("t3_count", 32'(fifo_count), 0);
    chk("t3_ferr", 32'(frame_err), 0);
    chk("t3_ovr", 32'(overrun), 0);
    frame(8'h81);
    chk("t3_count2", 32'(fifo_count), 1);
    chk("t3_data", 32'(rx_data), 'h81);
    pop1();

    // 17 frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) frame(8'(i));
    chk("t4_count", 32'(fifo_count), 16);
    chk("t4_ovr", 32'(overrun), 1);
    for (int i = 0; i < 16; i++) begin
      chk("t4_drain", 32'(rx_data), i);
      pop1();
    end
    chk("t4_empty", 32'(fifo_count), 0);
    chk("t4_valid", 32'(rx_valid), 0);
    clr1();
    chk("t4_ovr_clr", 32'(overrun), 0);

    // full FIFO, pop in the same cycle as the write
    for (int i = 0; i < 16; i++) frame(8'(8'h20 + i));
    chk("t5_full", 32'(fifo_count), 16);
    send(8'h30, 1'b1);
    wait_n(19);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("t5_count", 32'(fifo_count), 16);
    chk("t5_ovr", 32'(overrun), 0);
    chk("t5_head", 32'(rx_data), 'h21);
    wait_n(11);
    frame(8'h31);
    chk("t5_ovr_set", 32'(overrun), 1);

    // reset during data bit 4 of a partial 0xFF frame
    @(negedge clk);
    rxd = 1'b0;
    wait_n(32);
    rxd = 1'b1;
    wait_n(140);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t6_valid", 32'(rx_valid), 0);
    chk("t6_count", 32'(fifo_count), 0);
    chk("t6_data", 32'(rx_data), 0);
    chk("t6_ovr", 32'(overrun), 0);
    chk("t6_ferr", 32'(frame_err), 0);
    wait_n(400);
    chk("t6_no_partial", 32'(fifo_count), 0);
    chk("t6_ferr2", 32'(frame_err), 0);
    frame(8'hC7);
    chk("t6_c7_count", 32'(fifo_count), 1);
    chk("t6_c7_data", 32'(rx_data), 'hC7);
    pop1();

`ifdef UART_SINK_PARITY_EN
    chk("t7_perr0", 32'(parity_err), 0);
    par_flip = 1'b1;
    frame(8'hC7);
    par_flip = 1'b0;
    chk("t7_perr", 32'(parity_err), 1);
    chk("t7_no_push", 32'(fifo_count), 0);
    clr1();
    chk("t7_perr_clr", 32'(parity_err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
